// File: rtl/register_file.sv
//============================================================================
// Module      : register_file
// Description : Operand register file for the single-cycle datapath.
//               2**ADDR_W entries of DATA_W bits, two combinational read
//               ports (ALU operands A/B) and one synchronous write port
//               (ALU result). Entry 0 is hardwired to zero. A saturating
//               8-bit counter records committed writes for debug/test.
//
//               Optional feature macro: REGFILE_BYPASS_EN
//                 defined   : a read port whose address matches a pending
//                             commit returns wdata in the same cycle.
//                 undefined : read ports show stored contents only.
//
// Ports       : clk      - rising-edge clock for all state
//               rst      - synchronous, active-high reset
//               we       - write enable
//               waddr    - write address
//               wdata    - write data (ALU result)
//               raddr_a  - read address, port A
//               raddr_b  - read address, port B
//               rdata_a  - port A data (ALU operand A)
//               rdata_b  - port B data (ALU operand B)
//               wr_count - saturating count of committed writes
//
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [7:0]        wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage. Entry 0 exists only so the array can be indexed directly by
    // the address; it is never written and the read muxes mask it to zero.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [7:0]        wr_count_q;
    logic [7:0]        wr_count_d;

    // A commit is a write that actually lands: reset wins, and address 0
    // is a constant so writes to it are dropped (and not counted).
    logic w_commit;
    assign w_commit = we && !rst && (waddr != '0);

    //------------------------------------------------------------------------
    // Write counter next state: increments on each commit, sticks at 255.
    //------------------------------------------------------------------------
    always_comb begin
        wr_count_d = wr_count_q;
        if (w_commit && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    //------------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (w_commit) begin
                mem_q[waddr] <= wdata;
            end
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    //------------------------------------------------------------------------
    // Stored-contents read path (shared by both builds)
    //------------------------------------------------------------------------
    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    always_comb begin
        w_stored_a = '0;
        w_stored_b = '0;
        if (raddr_a != '0) begin
            w_stored_a = mem_q[raddr_a];
        end
        if (raddr_b != '0) begin
            w_stored_b = mem_q[raddr_b];
        end
    end

`ifdef REGFILE_BYPASS_EN
    //------------------------------------------------------------------------
    // Same-cycle forwarding. w_commit already excludes address 0 and reset,
    // so a match here can only ever forward a write that will really land.
    //------------------------------------------------------------------------
    logic w_fwd_a;
    logic w_fwd_b;

    assign w_fwd_a = w_commit && (raddr_a == waddr);
    assign w_fwd_b = w_commit && (raddr_b == waddr);

    always_comb begin
        rdata_a = w_stored_a;
        rdata_b = w_stored_b;
        if (w_fwd_a) begin
            rdata_a = wdata;
        end
        if (w_fwd_b) begin
            rdata_b = wdata;
        end
    end
`else
    // No forwarding: a read during a write returns the old contents.
    always_comb begin
        rdata_a = w_stored_a;
        rdata_b = w_stored_b;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none

module tb_register_file;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [7:0]        wr_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .wr_count (wr_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [DEPTH];
    int         m_cnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_cnt = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            m_cnt = 0;
        end else if (we && waddr != 0) begin
            m_mem[waddr] = wdata;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
    end

    function automatic logic [7:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (a == 0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && waddr == a) return wdata;
`endif
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_rdata_a", rdata_a, exp_rd(raddr_a));
            check("cmp_rdata_b", rdata_b, exp_rd(raddr_b));
            check("cmp_wr_count", wr_count, m_cnt[7:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic r, input logic w, input logic [2:0] wa,
                          input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
        rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        set_in(0, 1, a, d, 0, 0);
        tick();
    endtask

    task automatic idle_read(input logic [2:0] ra, input logic [2:0] rb);
        set_in(0, 0, 0, 0, ra, rb);
        #1;
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_en = 1;

        // Reset state
        idle_read(3, 6);
        check("reset_count", wr_count, 8'h00);
        check("reset_rd_a", rdata_a, 8'h00);
        check("reset_rd_b", rdata_b, 8'h00);

        // Fill all entries with 0xFF, then pulse reset
        for (int i = 0; i < DEPTH; i++) wr(i[2:0], 8'hFF);
        idle_read(7, 1);
        check("fill_rd_a", rdata_a, 8'hFF);
        check("fill_count", wr_count, 8'd7);
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle_read(i[2:0], 3'(7 - i));
            check("clr_rd_a", rdata_a, 8'h00);
            check("clr_rd_b", rdata_b, 8'h00);
        end
        check("clr_count", wr_count, 8'h00);

        // Basic write/read
        wr(3, 8'h5A);
        wr(5, 8'hA5);
        idle_read(3, 5);
        check("basic_rd_a", rdata_a, 8'h5A);
        check("basic_rd_b", rdata_b, 8'hA5);
        check("basic_count", wr_count, 8'd2);

        // Zero register
        wr(0, 8'h77);
        idle_read(0, 0);
        check("zero_rd_a", rdata_a, 8'h00);
        check("zero_rd_b", rdata_b, 8'h00);
        check("zero_count", wr_count, 8'd2);

        // Read-during-write
        wr(2, 8'h11);
        set_in(0, 1, 2, 8'h22, 2, 2);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_a", rdata_a, 8'h22);
`else
        check("rdw_before_a", rdata_a, 8'h11);
`endif
        tick();
        idle_read(2, 2);
        check("rdw_after_a", rdata_a, 8'h22);
        check("rdw_count", wr_count, 8'd4);

        // Reset versus simultaneous write
        set_in(1, 1, 4, 8'h33, 4, 4);
        tick();
        idle_read(4, 2);
        check("rstw_rd_a", rdata_a, 8'h00);
        check("rstw_rd_b", rdata_b, 8'h00);
        check("rstw_count", wr_count, 8'h00);

        // Randomised traffic, including occasional mid-sequence resets
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                   3'($urandom_range(0, 7)), 8'($urandom),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end

        // Saturation: 300 commits to r1 with data 0,1,2,...
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 300; i++) begin
            set_in(0, 1, 1, 8'(i), 1, 0);
            tick();
        end
        idle_read(1, 1);
        check("sat_count", wr_count, 8'hFF);
        check("sat_rd_a", rdata_a, 8'h2B);
        check("sat_rd_b", rdata_b, 8'h2B);
        tick();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
